mux_n_1_scan: RTL

Parametrised, registered N:1 multiplexer with an optional auto-scan mode. It is the next generation of the data-selector family: it supports arbitrary data width and channel count, and adds a one-cycle output register and valid flag. In scan mode a dwell counter steps through a channel mask, so a single downstream consumer can be time-shared across several sources without an external sequencer.

---
 rtl/mux_n_1_scan.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mux_n_1_scan.sv
// Registered N:1 data selector with a one-cycle output register, valid flag and optional auto-scan.
// Define MUX_N_1_SCAN_EN to build the scan state, dwell counter, mask stepping and Scan_Wrap_Out.
module mux_n_1_scan #(
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNELS    = 8,
    parameter int SEL_WIDTH   = 3,
    parameter int DWELL_WIDTH = 8
) (
    input  logic                           Clock_In,
    input  logic                           Reset_In,
    input  logic                           Enable_In,
    input  logic [CHANNELS*DATA_WIDTH-1:0] Data_In,
    input  logic                           Mode_In,
    input  logic [SEL_WIDTH-1:0]           Select_In,
    input  logic [DWELL_WIDTH-1:0]         Dwell_In,
    input  logic [CHANNELS-1:0]            Channel_Mask_In,
    output logic [DATA_WIDTH-1:0]          MUX_Result_Data_Out,
    output logic [SEL_WIDTH-1:0]           Channel_Out,
    output logic                           Valid_Out,
    output logic                           Scan_Wrap_Out
);

    function automatic logic [DATA_WIDTH-1:0] pick_data(
        input logic [CHANNELS*DATA_WIDTH-1:0] d,
        input logic [SEL_WIDTH-1:0]           s
    );
        pick_data = '0;
        for (int k = 0; k < CHANNELS; k++)
            if (int'(s) == k) pick_data = d[k*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [SEL_WIDTH-1:0]  chan_q, chan_d;
    logic                  valid_q, valid_d;
    logic                  sel_ok;

    assign sel_ok = int'(Select_In) < CHANNELS;

`ifdef MUX_N_1_SCAN_EN
    typedef enum logic {MANUAL, SCAN} state_t;

    function automatic int lowest_set(input logic [CHANNELS-1:0] m);
        lowest_set = 0;
        for (int k = CHANNELS - 1; k >= 0; k--)
            if (m[k]) lowest_set = k;
    endfunction

    state_t                   state_q, state_d;
    logic [DWELL_WIDTH-1:0]   cnt_q, cnt_d;
    logic                     wrap_q, wrap_d;
    logic [SEL_WIDTH-1:0]     first_chan, next_chan, chan_eff;
    logic                     cur_in_mask;
    logic [2*CHANNELS-1:0]    mask_rot;
    int                       next_sum;

    // A select left over from manual mode may exceed CHANNELS; fold it back so the
    // rotate-and-search below still yields the next index modulo CHANNELS.
    assign chan_eff    = (int'(chan_q) >= CHANNELS) ? SEL_WIDTH'(int'(chan_q) - CHANNELS) : chan_q;
    assign cur_in_mask = |(Channel_Mask_In & (CHANNELS'(1) << chan_q));
    assign first_chan  = SEL_WIDTH'(lowest_set(Channel_Mask_In));
    assign mask_rot    = {Channel_Mask_In, Channel_Mask_In} >> (int'(chan_eff) + 1);

    always_comb begin
        next_sum = int'(chan_eff) + 1 + lowest_set(mask_rot[CHANNELS-1:0]);
        if (next_sum >= CHANNELS) next_sum = next_sum - CHANNELS;
        next_chan = SEL_WIDTH'(next_sum);
    end
`else
    logic unused_scan_inputs;
    assign unused_scan_inputs = ^{Mode_In, Dwell_In, Channel_Mask_In};
`endif

    always_comb begin
        chan_d  = Select_In;
        data_d  = sel_ok ? pick_data(Data_In, Select_In) : '0;
        valid_d = sel_ok;
`ifdef MUX_N_1_SCAN_EN
        state_d = MANUAL;
        cnt_d   = '0;
        wrap_d  = 1'b0;
        if (Mode_In) begin
            state_d = SCAN;
            chan_d  = chan_q;
            if (Channel_Mask_In == '0) begin
                data_d  = '0;
                valid_d = 1'b0;
            end else begin
                if (state_q == MANUAL) begin
                    chan_d = first_chan;
                end else if (!cur_in_mask || cnt_q >= Dwell_In) begin
                    chan_d = next_chan;
                    wrap_d = next_chan <= chan_q;
                end else begin
                    cnt_d = cnt_q + DWELL_WIDTH'(1);
                end
                data_d  = pick_data(Data_In, chan_d);
                valid_d = 1'b1;
            end
        end
`endif
    end

    // Output stage: every register freezes while Enable_In is low.
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
        end else if (Enable_In) begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
        end
    end

`ifdef MUX_N_1_SCAN_EN
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q <= MANUAL;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else if (Enable_In) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign Scan_Wrap_Out = Enable_In & wrap_q;
`else
    assign Scan_Wrap_Out = 1'b0;
`endif

    assign MUX_Result_Data_Out = Enable_In ? data_q : 'z;
    assign Channel_Out         = chan_q;
    assign Valid_Out           = Enable_In & valid_q;

endmodule
